contador_programa: RTL and testbench
====================================

CONTADOR_PROGRAMA -- requirements
Module: contador_programa

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning instruction word address width.
REQ-002 SHALL have parameter MEM_DEPTH, default 7000, meaning instruction memory words; the address space is 0..MEM_DEPTH-1.
REQ-003 SHALL have parameter QUANTUM, default 100, meaning user-mode cycles before a timer trap.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port stall, input, 1, hold the PC.
REQ-007 SHALL have port branch_en, input, 1, load branch_addr.
REQ-008 SHALL have port branch_addr, input, ADDR_WIDTH, branch target.
REQ-009 SHALL have port syscall, input, 1, software trap request.
REQ-010 SHALL have port user_jump, input, 1, leave supervisor mode and enter user_addr.
REQ-011 SHALL have port user_addr, input, ADDR_WIDTH, user program entry or resume address.
REQ-012 SHALL have port endereco, output, ADDR_WIDTH, registered PC driving the instruction RAM address.
REQ-013 SHALL have port epc, output, ADDR_WIDTH, saved resume address of the last trap.
REQ-014 SHALL have port supervisor, output, 1, 1 = routine/OS mode, 0 = user program.
REQ-015 SHALL have port trap_cause, output, 2, 0 none, 1 syscall, 2 timer.

Function
REQ-016 SHALL compute next_seq per cycle: branch_addr if branch_en; else endereco if stall; else endereco+1, wrapping MEM_DEPTH-1 -> 0.
REQ-017 SHALL apply per-cycle priority: reset > trap > user_jump > branch_en > stall > increment.
REQ-018 SHALL take a trap when supervisor=0 and (syscall=1 or quantum_left=0): endereco<=CTX_BASE (0), epc<=next_seq, supervisor<=1, trap_cause<=1 for syscall, else 2; syscall wins when both occur.
REQ-019 SHALL ignore syscall and the timer while supervisor=1; there is no nesting.
REQ-020 SHALL, on user_jump while supervisor=1, set endereco<=user_addr, supervisor<=0, quantum_left<=QUANTUM-1.
REQ-021 SHALL ignore user_jump while supervisor=0.
REQ-022 SHALL decrement quantum_left once per user-mode clock, including stalled cycles, and never below 0.
REQ-023 SHALL give exactly QUANTUM endereco values in user mode between user_jump and the timer trap.
REQ-024 SHALL hold epc and trap_cause between traps; endereco changes only on the clock edge, giving the RAM one full cycle of setup.
REQ-025 SHALL reduce a branch_addr >= MEM_DEPTH modulo MEM_DEPTH.

Reset
REQ-026 SHALL, on reset, set endereco=SO_BASE (1000), supervisor=1, epc=0, trap_cause=0, quantum_left=0.
REQ-027 SHALL let reset mid-trap or mid-quantum discard all pending state with no trap recorded.

Configuration
REQ-028 SHALL, with PREEMPT_TIMER_EN defined, implement the quantum timer per REQ-022/023.
REQ-029 SHALL, without PREEMPT_TIMER_EN, omit the timer: only syscall traps, trap_cause is never 2, and QUANTUM is unused.

Structure
REQ-030 SHALL place CTX_BASE=0, SO_BASE=1000, PROG_BASE=2000, PROG_STRIDE=1000 and the trap-cause enum in shared package proc_pkg.
REQ-031 SHALL implement the countdown in sub-module quantum_timer (load, decrement, zero flag), instantiated only under PREEMPT_TIMER_EN.

Verification
REQ-032 SHALL cover this case: reset, then 3 free cycles -> endereco 1000,1001,1002,1003; supervisor=1.
REQ-033 SHALL cover this case: QUANTUM=4, user_jump to 2000 -> endereco 2000,2001,2002,2003, then 0; epc=2004, trap_cause=2.
REQ-034 SHALL cover this case: user mode at 3005 with syscall and branch_en to 3100 in the same cycle -> endereco 0, epc=3100, trap_cause=1.
REQ-035 SHALL cover this case: endereco 6999 with no branch -> next endereco 0; stall held 3 cycles in user mode -> address unchanged, quantum_left still decrements.
REQ-036 SHALL cover this case: syscall with supervisor=1 -> ignored; reset asserted mid-quantum -> endereco 1000, trap_cause=0.
REQ-037 SHALL cover this case: build without PREEMPT_TIMER_EN, 500 user cycles -> no trap taken.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared address map and trap-cause encoding for the program counter block.
package proc_pkg;

  localparam int CTX_BASE    = 0;
  localparam int SO_BASE     = 1000;
  localparam int PROG_BASE   = 2000;
  localparam int PROG_STRIDE = 1000;

  typedef enum logic [1:0] {
    TRAP_NONE    = 2'd0,
    TRAP_SYSCALL = 2'd1,
    TRAP_TIMER   = 2'd2
  } trap_cause_e;

endpackage

// File: rtl/quantum_timer.sv
// User-mode time slice countdown: load QUANTUM-1, decrement to a floor of 0, flag zero.
module quantum_timer #(
  parameter int QUANTUM = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int QW = (QUANTUM < 2) ? 1 : $clog2(QUANTUM + 1);

  logic [QW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = QW'(QUANTUM - 1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/contador_programa.sv
// Program counter with supervisor/user modes, syscall traps and (with PREEMPT_TIMER_EN)
// a preemptive quantum timer that forces a trap after QUANTUM user-mode cycles.
module contador_programa
  import proc_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 7000,
  parameter int QUANTUM    = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  syscall,
  input  logic                  user_jump,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  output logic [ADDR_WIDTH-1:0] endereco,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic                  supervisor,
  output logic [1:0]            trap_cause
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH     = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] CTX_ADDR  = ADDR_WIDTH'(CTX_BASE);
  localparam logic [ADDR_WIDTH-1:0] SO_ADDR   = ADDR_WIDTH'(SO_BASE);

  logic [ADDR_WIDTH-1:0] endereco_q, endereco_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic                  supervisor_q, supervisor_d;
  logic [1:0]            trap_cause_q, trap_cause_d;

  logic [ADDR_WIDTH-1:0] next_seq;
  logic                  timer_expired;
  logic                  take_trap;
  logic                  enter_user;

`ifdef PREEMPT_TIMER_EN
  logic timer_zero;

  // Counts every user-mode cycle, stalled or not; reloads on entry to user mode.
  quantum_timer #(
    .QUANTUM (QUANTUM)
  ) u_quantum_timer (
    .clock (clock),
    .reset (reset),
    .load  (enter_user),
    .dec   (!supervisor_q),
    .zero  (timer_zero)
  );

  assign timer_expired = timer_zero;
`else
  logic [31:0] quantum_unused;

  assign quantum_unused = QUANTUM;
  assign timer_expired  = 1'b0;
`endif

  always_comb begin
    if (branch_en) begin
      next_seq = branch_addr % DEPTH;
    end else if (stall) begin
      next_seq = endereco_q;
    end else if (endereco_q == LAST_ADDR) begin
      next_seq = '0;
    end else begin
      next_seq = endereco_q + 1'b1;
    end
  end

  assign take_trap  = !supervisor_q && (syscall || timer_expired);
  assign enter_user = supervisor_q && user_jump;

  always_comb begin
    endereco_d   = next_seq;
    epc_d        = epc_q;
    supervisor_d = supervisor_q;
    trap_cause_d = trap_cause_q;
    if (take_trap) begin
      // epc holds where the interrupted program would have gone next.
      endereco_d   = CTX_ADDR;
      epc_d        = next_seq;
      supervisor_d = 1'b1;
      trap_cause_d = syscall ? TRAP_SYSCALL : TRAP_TIMER;
    end else if (enter_user) begin
      endereco_d   = user_addr;
      supervisor_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      endereco_q   <= SO_ADDR;
      epc_q        <= '0;
      supervisor_q <= 1'b1;
      trap_cause_q <= TRAP_NONE;
    end else begin
      endereco_q   <= endereco_d;
      epc_q        <= epc_d;
      supervisor_q <= supervisor_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign endereco   = endereco_q;
  assign epc        = epc_q;
  assign supervisor = supervisor_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_contador_programa.sv
// Self-checking bench for contador_programa; timer sequences run when PREEMPT_TIMER_EN is defined.
module tb_contador_programa;

  localparam int AW = 32;
  localparam int EW = AW + 1 + AW + 2;

  typedef struct {
    logic          rst;
    logic          stall;
    logic          br;
    logic [AW-1:0] baddr;
    logic          sys;
    logic          uj;
    logic [AW-1:0] uaddr;
    logic [AW-1:0] e_end;
    logic          e_sup;
    logic [AW-1:0] e_epc;
    logic [1:0]    e_cause;
  } vec_t;

  logic          clock;
  logic          reset;
  logic          stall;
  logic          branch_en;
  logic [AW-1:0] branch_addr;
  logic          syscall;
  logic          user_jump;
  logic [AW-1:0] user_addr;
  logic [AW-1:0] endereco;
  logic [AW-1:0] epc;
  logic          supervisor;
  logic [1:0]    trap_cause;

  logic [EW-1:0] exp_q[$];
  int            checks;
  int            errors;
  vec_t          tbl[22];

  contador_programa #(
    .ADDR_WIDTH (AW),
    .MEM_DEPTH  (7000),
    .QUANTUM    (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .syscall     (syscall),
    .user_jump   (user_jump),
    .user_addr   (user_addr),
    .endereco    (endereco),
    .epc         (epc),
    .supervisor  (supervisor),
    .trap_cause  (trap_cause)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic rst, input logic st, input logic br, input int ba,
                              input logic sy, input logic uj, input int ua, input int e_end,
                              input logic e_sup, input int e_epc, input int e_cause);
    vec_t v;
    v.rst = rst; v.stall = st; v.br = br; v.baddr = AW'(ba); v.sys = sy; v.uj = uj;
    v.uaddr = AW'(ua); v.e_end = AW'(e_end); v.e_sup = e_sup; v.e_epc = AW'(e_epc);
    v.e_cause = 2'(e_cause);
    return v;
  endfunction

  // driver: apply one cycle of inputs, queue the expected state after the edge, then score
  task automatic apply(input vec_t v, input string name);
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    reset       = v.rst;
    stall       = v.stall;
    branch_en   = v.br;
    branch_addr = v.baddr;
    syscall     = v.sys;
    user_jump   = v.uj;
    user_addr   = v.uaddr;
    exp_q.push_back({v.e_end, v.e_sup, v.e_epc, v.e_cause});
    @(posedge clock);
    #1;
    exp_v = exp_q.pop_front();
    act_v = {endereco, supervisor, epc, trap_cause};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got endereco=%0d sup=%0b epc=%0d cause=%0d, expected endereco=%0d sup=%0b epc=%0d cause=%0d",
               name, endereco, supervisor, epc, trap_cause,
               exp_v[EW-1 -: AW], exp_v[AW+2], exp_v[AW+1:2], exp_v[1:0]);
    end
  endtask

  task automatic free_cycle(input int e_end, input logic e_sup, input int e_epc,
                            input int e_cause, input string name);
    apply(mk(0, 0, 0, 0, 0, 0, 0, e_end, e_sup, e_epc, e_cause), name);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_addr = '0;
    syscall = 1'b0; user_jump = 1'b0; user_addr = '0;

    //              rst st br baddr sy uj uaddr  end  sup epc   cause
    tbl[0]  = mk(1, 0, 0, 0,    0, 0, 0,    1000, 1, 0,    0);
    tbl[1]  = mk(0, 0, 0, 0,    0, 0, 0,    1001, 1, 0,    0);
    tbl[2]  = mk(0, 0, 0, 0,    0, 0, 0,    1002, 1, 0,    0);
    tbl[3]  = mk(0, 0, 0, 0,    0, 0, 0,    1003, 1, 0,    0);
    tbl[4]  = mk(0, 0, 0, 0,    1, 0, 0,    1004, 1, 0,    0);
    tbl[5]  = mk(0, 0, 1, 3000, 0, 0, 0,    3000, 1, 0,    0);
    tbl[6]  = mk(0, 1, 0, 0,    0, 0, 0,    3000, 1, 0,    0);
    tbl[7]  = mk(0, 1, 1, 3010, 0, 0, 0,    3010, 1, 0,    0);
    tbl[8]  = mk(0, 0, 1, 7005, 0, 0, 0,    5,    1, 0,    0);
    tbl[9]  = mk(0, 0, 1, 6999, 0, 0, 0,    6999, 1, 0,    0);
    tbl[10] = mk(0, 0, 0, 0,    0, 0, 0,    0,    1, 0,    0);
    tbl[11] = mk(0, 0, 1, 9,    0, 1, 3005, 3005, 0, 0,    0);
    tbl[12] = mk(0, 0, 1, 3100, 1, 0, 0,    0,    1, 3100, 1);
    tbl[13] = mk(0, 0, 0, 0,    0, 1, 2000, 2000, 0, 3100, 1);
    tbl[14] = mk(0, 0, 0, 0,    0, 1, 50,   2001, 0, 3100, 1);
    tbl[15] = mk(0, 1, 0, 0,    0, 0, 0,    2001, 0, 3100, 1);
    tbl[16] = mk(0, 1, 0, 0,    1, 0, 0,    0,    1, 2001, 1);
    tbl[17] = mk(0, 0, 0, 0,    0, 0, 0,    1,    1, 2001, 1);
    tbl[18] = mk(0, 0, 0, 0,    0, 1, 4000, 4000, 0, 2001, 1);
    tbl[19] = mk(0, 0, 0, 0,    0, 0, 0,    4001, 0, 2001, 1);
    tbl[20] = mk(1, 0, 0, 0,    1, 0, 0,    1000, 1, 0,    0);
    tbl[21] = mk(0, 0, 0, 0,    0, 0, 0,    1001, 1, 0,    0);

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

`ifdef PREEMPT_TIMER_EN
    // timer trap after exactly QUANTUM user addresses
    apply(mk(0, 0, 0, 0, 0, 1, 2000, 2000, 0, 0, 0), "tq_jump");
    free_cycle(2001, 0, 0, 0, "tq_1");
    free_cycle(2002, 0, 0, 0, "tq_2");
    free_cycle(2003, 0, 0, 0, "tq_3");
    free_cycle(0, 1, 2004, 2, "tq_trap");
    // stalled user cycles still consume the quantum
    apply(mk(0, 0, 0, 0, 0, 1, 3000, 3000, 0, 2004, 2), "ts_jump");
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 1, 0, 0, 0, 0, 0, 3000, 0, 2004, 2), $sformatf("ts_stall%0d", i));
    end
    free_cycle(0, 1, 3001, 2, "ts_trap");
    // syscall and timer expiry together report syscall
    apply(mk(0, 0, 0, 0, 0, 1, 100, 100, 0, 3001, 2), "tb_jump");
    free_cycle(101, 0, 3001, 2, "tb_1");
    free_cycle(102, 0, 3001, 2, "tb_2");
    free_cycle(103, 0, 3001, 2, "tb_3");
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 104, 1), "tb_both");
`else
    // no timer: a long user run never traps on its own
    apply(mk(0, 0, 0, 0, 0, 1, 2000, 2000, 0, 0, 0), "nt_jump");
    for (int i = 1; i <= 500; i++) begin
      free_cycle(2000 + i, 0, 0, 0, $sformatf("nt_run%0d", i));
    end
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 2501, 1), "nt_syscall");
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    checks++;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
